serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop produce A+B+ci
// LSB first over WIDTH cycles, sequenced by an IDLE/RUN/DONE controller.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    // One spare counter bit so the final increment to WIDTH never wraps.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic             load;
    logic             shift;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_co;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .ci  (carry),
        .sum (fa_sum),
        .co  (fa_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 holds the first one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            result <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= ci;
            cnt   <= '0;
        end else if (shift) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            result <= {fa_sum, result[WIDTH-1:1]};
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign sum = result;
    assign co  = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomized checks of serial_add_ctrl at WIDTH=8 and WIDTH=16.

module tb_serial_add_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        ci;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        co;

    logic        start16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        ci16;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        co16;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .co      (co)
    );

    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start16),
        .a       (a16),
        .b       (b16),
        .ci      (ci16),
        .busy    (busy16),
        .done    (done16),
        .sum     (sum16),
        .co      (co16)
    );

    // Called at a falling edge while the DUT is IDLE; returns at the falling
    // edge of the cycle where done is seen (or after a 40-cycle bound).
    // Operands are inverted right after acceptance; optional start pulse at RUN cycle pulse_at.
    task automatic do_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                         input int pulse_at, output int lat, output int busy_cycles);
        a = aa; b = bb; ci = cc; start = 1'b1;
        lat = 0; busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; a = ~aa; b = ~bb; ci = ~cc;
            end
            if (pulse_at != 0 && lat == pulse_at) start = 1'b1;
            if (pulse_at != 0 && lat == pulse_at + 1) start = 1'b0;
            if (busy === 1'b1) busy_cycles++;
        end while (done !== 1'b1 && lat < 40);
    endtask

    task automatic test_reset;
        reset_n = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        start16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0;
        #2 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passes++;
        checks++; if (sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", sum); else passes++;
        checks++; if (co !== 1'b0) $display("FAIL reset_co got=%b exp=0", co); else passes++;
    endtask

    // Reset is released on the same falling edge the start is raised, so the
    // first rising edge after release must accept it.
    task automatic test_basic;
        int lat, bc;
        reset_n = 1'b1;
        do_op(8'h35, 8'h4A, 1'b0, 0, lat, bc);
        checks++; if (lat !== 9) $display("FAIL basic_latency got=%0d exp=9", lat); else passes++;
        checks++; if (bc !== 8) $display("FAIL basic_busy_cycles got=%0d exp=8", bc); else passes++;
        checks++; if (sum !== 8'h7F) $display("FAIL basic_sum got=%h exp=7f", sum); else passes++;
        checks++; if (co !== 1'b0) $display("FAIL basic_co got=%b exp=0", co); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL basic_done_width got=%b exp=0", done); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b exp=0", busy); else passes++;
        repeat (3) @(negedge clk);
        checks++; if ({co, sum} !== 9'h07F) $display("FAIL basic_hold got=%h exp=07f", {co, sum}); else passes++;
    endtask

    task automatic test_carry;
        int lat, bc;
        do_op(8'hFF, 8'h00, 1'b1, 0, lat, bc);
        checks++; if (lat !== 9) $display("FAIL carry_latency got=%0d exp=9", lat); else passes++;
        checks++; if (sum !== 8'h00) $display("FAIL carry_sum got=%h exp=00", sum); else passes++;
        checks++; if (co !== 1'b1) $display("FAIL carry_co got=%b exp=1", co); else passes++;
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int lat, bc, extra_done, extra_busy;
        do_op(8'hFF, 8'hFF, 1'b1, 3, lat, bc);
        checks++; if (lat !== 9) $display("FAIL ignore_latency got=%0d exp=9", lat); else passes++;
        checks++; if (sum !== 8'hFF) $display("FAIL ignore_sum got=%h exp=ff", sum); else passes++;
        checks++; if (co !== 1'b1) $display("FAIL ignore_co got=%b exp=1", co); else passes++;
        extra_done = 0; extra_busy = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
            if (busy === 1'b1) extra_busy++;
        end
        checks++; if (extra_done !== 0) $display("FAIL ignore_extra_done got=%0d exp=0", extra_done); else passes++;
        checks++; if (extra_busy !== 0) $display("FAIL ignore_extra_busy got=%0d exp=0", extra_busy); else passes++;
    endtask

    task automatic test_reset_mid_run;
        int lat, bc, cyc, seen;
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        cyc = 0;
        repeat (4) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
        end
        checks++; if (busy !== 1'b1) $display("FAIL midrun_busy_before got=%b exp=1", busy); else passes++;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sum !== 8'h00) $display("FAIL midrun_async_sum got=%h exp=00", sum); else passes++;
        checks++; if (co !== 1'b0) $display("FAIL midrun_async_co got=%b exp=0", co); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrun_async_busy got=%b exp=0", busy); else passes++;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) $display("FAIL midrun_no_done got=%0d exp=0", seen); else passes++;
        reset_n = 1'b1;
        do_op(8'h01, 8'h01, 1'b0, 0, lat, bc);
        checks++; if (lat !== 9) $display("FAIL midrun_after_latency got=%0d exp=9", lat); else passes++;
        checks++; if (sum !== 8'h02) $display("FAIL midrun_after_sum got=%h exp=02", sum); else passes++;
        checks++; if (co !== 1'b0) $display("FAIL midrun_after_co got=%b exp=0", co); else passes++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] va[3];
        logic [7:0] vb[3];
        logic       vc[3];
        logic [8:0] expv;
        int k, cyc, last_done;
        va = '{8'h10, 8'h7F, 8'hAA};
        vb = '{8'h20, 8'h01, 8'h55};
        vc = '{1'b1, 1'b0, 1'b1};
        k = 0; cyc = 0; last_done = 0;
        a = va[0]; b = vb[0]; ci = vc[0]; start = 1'b1;
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                expv = 9'(va[k]) + 9'(vb[k]) + 9'(vc[k]);
                checks++; if ({co, sum} !== expv) $display("FAIL b2b_result%0d got=%h exp=%h", k, {co, sum}, expv); else passes++;
                if (k == 0) begin
                    checks++; if (cyc !== 9) $display("FAIL b2b_first_latency got=%0d exp=9", cyc); else passes++;
                end else begin
                    checks++; if (cyc - last_done !== 10) $display("FAIL b2b_spacing%0d got=%0d exp=10", k, cyc - last_done); else passes++;
                end
                last_done = cyc;
                k++;
                if (k < 3) begin
                    a = va[k]; b = vb[k]; ci = vc[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++; if (k !== 3) $display("FAIL b2b_done_count got=%0d exp=3", k); else passes++;
        @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0]  ra, rb;
        logic [15:0] wa, wb;
        logic        rc;
        logic [8:0]  exp8;
        logic [16:0] exp16;
        int n;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
            a = ra; b = rb; ci = rc; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (done !== 1'b1 && n < 30) begin
                @(negedge clk);
                n++;
            end
            exp8 = 9'(ra) + 9'(rb) + 9'(rc);
            checks++; if ({co, sum} !== exp8) $display("FAIL rand8_%0d got=%h exp=%h", i, {co, sum}, exp8); else passes++;
            @(negedge clk);
        end
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                wa = 16'hFFFF; wb = 16'hFFFF; rc = 1'b1;
            end else begin
                wa = 16'($urandom); wb = 16'($urandom); rc = 1'($urandom_range(0, 1));
            end
            a16 = wa; b16 = wb; ci16 = rc; start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            n = 0;
            while (done16 !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            exp16 = 17'(wa) + 17'(wb) + 17'(rc);
            checks++; if ({co16, sum16} !== exp16) $display("FAIL rand16_%0d got=%h exp=%h", i, {co16, sum16}, exp16); else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
